// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit that owns HI/LO: shift-add multiply, restoring divide, single-cycle MTHI/MTLO.
// Latency WIDTH+2 edges from Start to Done; Busy high WIDTH+1 cycles; Start while Busy is dropped, Flush cancels.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               bzero_q, bzero_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;

  logic               op_arith, op_div, signed_op;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum, rem_ext, rem_diff;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_new, quot, rem;
  logic [2*WIDTH-1:0] step_acc, prod;

  always_comb begin
    op_arith  = ~Op[2];
    op_div    = Op[1];
    signed_op = ~Op[0];
    mag1      = (signed_op && In1[WIDTH-1]) ? -In1 : In1;
    mag2      = (signed_op && In2[WIDTH-1]) ? -In2 : In2;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rem_ext  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_ext - {1'b0, opnd_q};
    rem_ge   = ~rem_diff[WIDTH];
    rem_new  = rem_ge ? rem_diff[WIDTH-1:0] : rem_ext[WIDTH-1:0];
    step_acc = is_div_q ? {rem_new, acc_q[WIDTH-2:0], rem_ge}
                        : {mul_sum, acc_q[WIDTH-1:1]};
    prod     = neg_q ? -acc_q : acc_q;
    // a zero divisor leaves the dividend magnitude in the remainder, so sign fix-up yields In1
    quot     = bzero_q ? {WIDTH{1'b1}}
                       : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start && op_arith) state_d = S_CALC;
      S_CALC:  if (Flush) state_d = S_IDLE;
               else if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy    = (state_q != S_IDLE);
    Done    = done_q;
    DivZero = divzero_q;
    HI      = hi_q;
    LO      = lo_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    bzero_d   = bzero_q;
    divzero_d = divzero_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (Op == OP_MTHI) begin
            hi_d = In1;
          end else if (Op == OP_MTLO) begin
            lo_d = In1;
          end else if (op_arith) begin
            is_div_d = op_div;
            neg_d    = signed_op & (In1[WIDTH-1] ^ In2[WIDTH-1]);
            rneg_d   = signed_op & In1[WIDTH-1];
            bzero_d  = op_div & (In2 == {WIDTH{1'b0}});
            opnd_d   = op_div ? mag2 : mag1;
            acc_d    = {{WIDTH{1'b0}}, (op_div ? mag1 : mag2)};
            cnt_d    = CNT_W'(WIDTH);
          end
        end
      end
      S_CALC: begin
        if (Flush) begin
          cnt_d = '0;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FIX: begin
        cnt_d = '0;
        if (!Flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d      = rem;
            lo_d      = quot;
            divzero_d = bzero_q;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      bzero_q   <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      bzero_q   <= bzero_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: a reference model pushes expected HI/LO/DivZero at issue, Done pops them.
module tb_mul_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start, flush;
  logic [2:0]   op;
  logic [W-1:0] in1, in2;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  logic         start8, flush8;
  logic [2:0]   op8;
  logic [7:0]   in1_8, in2_8;
  logic         busy8, done8, dz8;
  logic [7:0]   hi8, lo8;

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .Start(start), .Op(op), .In1(in1), .In2(in2),
    .Flush(flush), .Busy(busy), .Done(done), .DivZero(dz), .HI(hi), .LO(lo)
  );

  mul_div_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .Start(start8), .Op(op8), .In1(in1_8), .In2(in2_8),
    .Flush(flush8), .Busy(busy8), .Done(done8), .DivZero(dz8), .HI(hi8), .LO(lo8)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  logic dz_model;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic dz_prev);
    exp_t        e;
    longint      sa, sbv;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    e.dz = dz_prev;
    e.hi = '0;
    e.lo = '0;
    case (o)
      3'd0: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd2, 3'd3: begin
        e.dz = (b == 0);
        if (b == 0) begin
          e.hi = a;
          e.lo = '1;
        end else if (o == 3'd2) begin
          e.lo = 32'(sa / sbv);
          e.hi = 32'(sa % sbv);
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("hi", hi, mon_e.hi);
        chk("lo", lo, mon_e.lo);
        chk("divzero", dz, mon_e.dz);
      end
    end
  end

  // poke_at > 0 re-pulses Start on that busy cycle; fl drives Flush alongside the accepted Start
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke_at, input logic fl);
    exp_t e;
    int   cyc;
    e = model(o, a, b, dz_model);
    dz_model = e.dz;
    @(negedge clk);
    start = 1'b1; op = o; in1 = a; in2 = b; flush = fl;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0; flush = 1'b0; in1 = $urandom; in2 = $urandom;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (cyc == poke_at) begin
        start = 1'b1; op = 3'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", cyc, W + 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [2:0] ro;
    logic [W-1:0] ra, rb;
    start = 0; flush = 0; op = 0; in1 = 0; in2 = 0;
    start8 = 0; flush8 = 0; op8 = 0; in1_8 = 0; in2_8 = 0;
    dz_model = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'hFFFFFFFE, 32'h3, 0, 1'b0);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h1);
    run_op(3'd2, 32'hFFFFFFF9, 32'h2, 0, 1'b0);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(3'd3, 32'd100, 32'd7, 0, 1'b0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    run_op(3'd3, 32'h1234, 32'h0, 0, 1'b0);
    chk("dz_lo", lo, 32'hFFFFFFFF);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_flag", dz, 1);
    run_op(3'd0, 32'd5, 32'd7, 0, 1'b0);
    chk("dz_kept_by_mult", dz, 1);
    run_op(3'd2, 32'hFFFFFFF0, 32'h0, 0, 1'b0);
    chk("sdz_hi", hi, 32'hFFFFFFF0);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);
    chk("dz_cleared", dz, 0);
    run_op(3'd3, 32'd100, 32'd7, 5, 1'b0);
    chk("busy_start_lo", lo, 32'd14);
    run_op(3'd1, 32'd3, 32'd4, 0, 1'b1);
    chk("start_flush_lo", lo, 32'd12);

    @(negedge clk);
    start = 1'b1; op = 3'd4; in1 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'hA5A5A5A5);
    chk("mthi_busy", busy, 0);
    @(negedge clk);
    op = 3'd5; in1 = 32'h5A5A5A5A;
    @(negedge clk);
    op = 3'd6; in1 = 32'h11111111; in2 = 32'h2;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h5A5A5A5A);
    chk("noop_hi", hi, 32'hA5A5A5A5);
    chk("noop_busy", busy, 0);

    start = 1'b1; op = 3'd0; in1 = 32'd1234; in2 = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_busy", busy, 0);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    chk("flush_hi", hi, 32'hA5A5A5A5);
    chk("flush_lo", lo, 32'h5A5A5A5A);

    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      if (i % 5 == 0) rb = '0;
      else if (i % 3 == 0) rb = $urandom_range(1, 9);
      else rb = $urandom;
      run_op(ro, ra, rb, 0, 1'b0);
    end

    run_op(3'd1, 32'd9, 32'd9, 0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd0; in1 = 32'd7; in2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    dz_model = 1'b0;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_dz", dz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd1, 32'd6, 32'd7, 0, 1'b0);
    chk("post_rst_lo", lo, 32'd42);

    @(negedge clk);
    start8 = 1'b1; op8 = 3'd1; in1_8 = 8'hFF; in2_8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    while (busy8 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("w8_busy_cycles", cyc, 9);
    chk("w8_done", done8, 1);
    chk("w8_hi", hi8, 8'hFE);
    chk("w8_lo", lo8, 8'h01);

    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit for the MIPS datapath. Sits beside the single-cycle ALU in EX.
- Owns the HI/LO architectural registers and executes MULT/MULTU/DIV/DIVU over multiple cycles using a Start/Busy/Done handshake.
- Also executes MTHI/MTLO single-cycle writes. The pipeline stalls on Busy for MFHI/MFLO and for new mul/div operations.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; must be >= 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Start  input  1  request; sampled only when Busy=0
- Op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- In1  input  WIDTH  rs operand: multiplicand or dividend; source for MTHI/MTLO
- In2  input  WIDTH  rt operand: multiplier or divisor
- Flush  input  1  cancels an in-flight operation (exception or branch squash)
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse when HI/LO are updated by mul/div
- DivZero  output  1  sticky flag: the last completed divide had In2=0
- HI  output  WIDTH  HI register (product upper half / remainder)
- LO  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (rst_n=0, asynchronous): HI=0, LO=0, Busy=0, Done=0, DivZero=0, state=IDLE, counter=0.
- States: IDLE, CALC, FIX.
- IDLE, Start=1, Op=MTHI or MTLO: HI (or LO) <= In1 at the same edge. Stay in IDLE. No Busy, no Done.
- IDLE, Start=1, Op 0-3:
  - Latch the operand magnitudes; signed ops use absolute values and record the result signs.
  - Clear the accumulator; counter <= WIDTH; go to CALC. Busy=1 from the next cycle.
- IDLE, Start=1, Op 6/7: ignored.
- CALC, multiply: one shift-add step per cycle, LSB-first on the multiplier, producing a 2*WIDTH-bit product.
- CALC, divide: one restoring-division step per cycle, MSB-first, producing a WIDTH-bit quotient and remainder.
- CALC: decrement the counter each cycle; go to FIX when the counter reaches 1.
- FIX: apply sign correction and write results, then go to IDLE.
  - Product: negate if the operand signs differ. HI = upper half, LO = lower half.
  - Quotient: negate if the signs differ (truncation toward zero). Remainder takes the sign of the dividend. HI = remainder, LO = quotient.
  - At the FIX exit edge: HI/LO update, Done=1 for exactly one cycle, Busy=0.
- Latency: Start accepted at edge k; HI/LO valid and Done=1 in the cycle after edge k+WIDTH+1. Busy is high for WIDTH+1 cycles.
- Start while Busy=1 is ignored; no queueing. MTHI/MTLO while busy are ignored; the pipeline must not issue them.
- Divide by zero (In2=0): no exception. Result is LO = all ones and HI = In1 for both DIV and DIVU. DivZero is set at Done.
- DivZero clears at the next accepted divide's Done with a nonzero divisor. Multiplies do not alter it.
- Signed overflow case (DIV, most-negative / -1): LO = most-negative, HI = 0. No flag.
- Flush=1 in CALC or FIX: return to IDLE at the next edge, Busy=0, no Done, HI/LO unchanged.
- Flush in IDLE has no effect. Flush has priority over a same-cycle FIX writeback.
- Simultaneous Start and Flush in IDLE: Start is accepted; Flush applies only to an in-flight operation.
- Operands are captured at acceptance; In1/In2 changes during Busy have no effect.
- All arithmetic is modulo 2^(2*WIDTH) for products and WIDTH bits for quotient and remainder. No Overflow output.

Test Plan:
- Reset mid-CALC: assert rst_n=0 after 5 cycles of MULT -> Busy=0, Done=0, HI=LO=0 immediately, without waiting for an edge.
- MULT In1=0xFFFFFFFE (-2), In2=0x00000003, WIDTH=32 -> after 33 Busy cycles, Done=1 for one cycle; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU In1=0xFFFFFFFF, In2=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV In1=-7 (0xFFFFFFF9), In2=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU In1=100, In2=7 -> LO=14, HI=2, DivZero=0.
- DIVU In1=0x1234, In2=0 -> LO=0xFFFFFFFF, HI=0x1234, DivZero=1.
- MULT started, Flush at cycle 10 -> Busy drops next edge, no Done, HI/LO keep prior values.
- Start pulsed again while Busy -> ignored; the original result still appears.
- MTHI In1=0xA5A5A5A5 while idle -> HI=0xA5A5A5A5 next cycle, Busy stays 0.
- DIV In1=0x80000000, In2=0xFFFFFFFF -> LO=0x80000000, HI=0.
- WIDTH=8 rerun: MULTU 0xFF*0xFF -> HI=0xFE, LO=0x01 after 9 Busy cycles.
